// File: rtl/pipe_skid.sv
// ---------------------------------------------------------------------------
// pipe_skid -- two-entry skid register slice with valid/ready on both sides.
//
// Sits between pipeline stages so a downstream stall never reaches the
// upstream side combinationally. It sustains one word per cycle, has one
// cycle of latency, and drives in_ready straight from a flop.
//
// Ports
//   clk        in   1      clock, all state updates on posedge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      producer has data on in_data
//   in_ready   out  1      slice can accept (registered)
//   in_data    in   width  producer data
//   out_valid  out  1      out_data is valid
//   out_ready  in   1      consumer takes out_data this cycle
//   out_data   out  width  registered output data (main entry)
//   flush      in   1      synchronous discard of both entries
//                          (present only when PIPE_SKID_FLUSH_EN is defined)
//
// Build option
//   PIPE_SKID_FLUSH_EN  adds the flush port. When it is undefined, only rst
//                       clears the slice.
// ---------------------------------------------------------------------------
module pipe_skid #(
   parameter int               width      = 32,
   parameter logic [width-1:0] flush_data = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [width-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [width-1:0] out_data
`ifdef PIPE_SKID_FLUSH_EN
   ,
   input  logic             flush
`endif
);

   // EMPTY: no data, FULL: main entry only, SKID: main and skid entries.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [width-1:0] main_q, main_d;
   logic [width-1:0] skid_q;
   logic             skid_load;
   logic             in_ready_q;
   logic             in_acc, out_acc;

   assign out_valid = (state_q != EMPTY);
   assign in_ready  = in_ready_q;
   assign out_data  = main_q;

   assign in_acc  = in_valid & in_ready_q;
   assign out_acc = out_valid & out_ready;

   // NOTE: every signal driven here gets its default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      main_d    = main_q;
      skid_load = 1'b0;

      unique case (state_q)
         EMPTY: begin
            if (in_acc) begin
               state_d = FULL;
               main_d  = in_data;
            end
         end
         FULL: begin
            if (in_acc && out_acc) begin
               main_d = in_data;
            end else if (in_acc) begin
               // The consumer stalled, so park the new word behind the main entry.
               state_d   = SKID;
               skid_load = 1'b1;
            end else if (out_acc) begin
               // main_q keeps its last value. It is not observable while EMPTY.
               state_d = EMPTY;
            end
         end
         SKID: begin
            if (out_acc) begin
               state_d = FULL;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase

`ifdef PIPE_SKID_FLUSH_EN
      // A flush overrides any accept in the same cycle, so the input word is dropped.
      if (flush) begin
         state_d   = EMPTY;
         main_d    = flush_data;
         skid_load = 1'b0;
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         main_q     <= flush_data;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         // Register in_ready from the next state so it never depends on out_ready combinationally.
         in_ready_q <= (state_d != SKID);
      end
   end

   // NOTE: the skid word has no reset. It is read only in SKID, which always follows a load.
   always_ff @(posedge clk) begin
      if (skid_load) begin
         skid_q <= in_data;
      end
   end

endmodule

// File: tb/tb_pipe_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid -- self-checking bench for pipe_skid.
//
// Directed sequences drive the inputs. A monitor runs on the falling edge.
// It pushes every accepted input word into a queue. It pops and compares
// every word the consumer takes. It also checks that out_valid and out_data
// hold steady while the output is stalled.
// ---------------------------------------------------------------------------
module tb_pipe_skid;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         flush = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] sb[$];
   bit           stall_prev = 1'b0;
   logic [W-1:0] stall_data = '0;

   pipe_skid #(.width(W), .flush_data('0)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef PIPE_SKID_FLUSH_EN
      ,
      .flush     (flush)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Return one time unit after the next rising edge. Inputs change here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard and stall monitor. It samples mid-cycle, so the values seen
   // here are the ones the next rising edge acts on.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", {31'b0, out_valid}, 1);
            check("stall_data", out_data, stall_data);
         end
         if (flush) begin
            sb.delete();
            stall_prev = 1'b0;
         end else begin
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL order: got %h expected nothing (queue empty) at %0t", out_data, $time);
               end else begin
                  check("order", out_data, sb.pop_front());
               end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
         end
      end
   end

   // Sets up the sequence out_ready=0, push a, push b. The slice ends in SKID with a in main.
   task automatic fill_skid(input logic [W-1:0] a, input logic [W-1:0] b);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = a;
      step();
      in_data   = b;
      step();
      in_valid  = 1'b0;
   endtask

   initial begin
      // 1: reset state
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      repeat (2) step();
      check("t1_out_valid", {31'b0, out_valid}, 0);
      check("t1_in_ready", {31'b0, in_ready}, 1);
      check("t1_out_data", out_data, 0);

      // 2: streaming with out_ready high, one-cycle latency
      out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         in_valid = 1'b1;
         in_data  = i;
         check("t2_in_ready", {31'b0, in_ready}, 1);
         step();
         check("t2_out_valid", {31'b0, out_valid}, 1);
         check("t2_out_data", out_data, i);
      end
      in_valid = 1'b0;
      step();
      check("t2_drained", {31'b0, out_valid}, 0);

      // 3: stall fills skid, then drain in order
      fill_skid(32'hA, 32'hB);
      check("t3_in_ready_low", {31'b0, in_ready}, 0);
      check("t3_out_data_a", out_data, 32'hA);
      repeat (3) step();
      check("t3_hold_a", out_data, 32'hA);
      check("t3_hold_ready", {31'b0, in_ready}, 0);
      out_ready = 1'b1;
      step();
      check("t3_out_data_b", out_data, 32'hB);
      check("t3_in_ready_back", {31'b0, in_ready}, 1);
      step();
      check("t3_empty", {31'b0, out_valid}, 0);

      // 4: random handshakes against the scoreboard
      for (int c = 0; c < 10000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && sb.size() != 0; c++) step();
      step();
      check("t4_drain_empty", sb.size(), 0);
      check("t4_out_valid", {31'b0, out_valid}, 0);

      // 5: async reset while in SKID holding 5,6
      fill_skid(32'h5, 32'h6);
      check("t5_skid", {31'b0, in_ready}, 0);
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      check("t5_rst_out_valid", {31'b0, out_valid}, 0);
      check("t5_rst_in_ready", {31'b0, in_ready}, 1);
      check("t5_rst_out_data", out_data, 0);
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (5) begin
         step();
         check("t5_no_stale", {31'b0, out_valid}, 0);
      end

`ifdef PIPE_SKID_FLUSH_EN
      // 6a: flush in SKID with in_valid high
      fill_skid(32'h11, 32'h22);
      in_valid  = 1'b1;
      in_data   = 32'h33;
      out_ready = 1'b1;
      flush     = 1'b1;
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      check("t6_out_valid", {31'b0, out_valid}, 0);
      check("t6_in_ready", {31'b0, in_ready}, 1);
      check("t6_out_data", out_data, 0);
      repeat (3) begin
         step();
         check("t6_no_stale", {31'b0, out_valid}, 0);
      end
      // 6b: flush in FULL with a real input accept and an output accept
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h44;
      step();
      in_data   = 32'h55;
      out_ready = 1'b1;
      flush     = 1'b1;
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      check("t6b_out_valid", {31'b0, out_valid}, 0);
      check("t6b_out_data", out_data, 0);
      repeat (3) begin
         step();
         check("t6b_dropped", {31'b0, out_valid}, 0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
